// File: rtl/fifo_pkg.sv
// Shared defaults and pointer type for the single-clock FIFO.
// Pointers carry one extra wrap bit above the memory address bits.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_PTR_W      = $clog2(DEFAULT_DEPTH);

  // Pointer at the default depth: MSB is the wrap bit, low bits address memory.
  typedef logic [DEFAULT_PTR_W:0] ptr_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: one write port, one registered read port.
// Only the read register is reset; storage contents are left untouched.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value whenever no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = DEFAULT_DEPTH,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  output logic                  overflow,
  output logic                  underflow
);

  typedef logic [PTR_W:0] fifo_ptr_t;

  fifo_ptr_t wr_ptr;
  fifo_ptr_t rd_ptr;
  logic      wr_acc;
  logic      rd_acc;

  // Flags come straight from registered pointers, so they never glitch mid-cycle.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign count = wr_ptr - rd_ptr;

  // Blocking on full/empty also prevents read-through and same-address collisions.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= w_en & full;
      underflow <= r_en & empty;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[PTR_W-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[PTR_W-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed vector table, hand-written reset/wrap
// sequences, and randomized traffic against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int n_chk  = 0;
  int n_fail = 0;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .w_en      (w_en),
    .r_en      (r_en),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // {full, empty, overflow, underflow, count[3:0], data_out[7:0]}
  typedef struct {
    bit          w;
    bit          r;
    logic [7:0]  din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit w, bit r, logic [7:0] din, bit f, bit e,
                              bit ov, bit un, int cnt, logic [7:0] dout);
    vec_t v;
    v.w   = w;
    v.r   = r;
    v.din = din;
    v.exp = {f, e, ov, un, 4'(cnt), dout};
    return v;
  endfunction

  function automatic logic [15:0] outs();
    return {full, empty, overflow, underflow, count, data_out};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (f,e,ov,un,cnt,dout)", name, act, req);
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d);
    @(negedge clk);
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ov;
  bit         m_un;

  initial begin
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = '0;

    // Fill/overflow/drain, boundary simultaneous ops, half-full streaming.
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 0, 8'(i), i == 8, 0, 0, 0, i, 8'h00));
    tbl.push_back(mk(1, 0, 8'hFF, 1, 0, 1, 0, 8, 8'h00));
    tbl.push_back(mk(1, 1, 8'hEE, 0, 0, 1, 0, 7, 8'h01));
    for (int k = 2; k <= 8; k++) tbl.push_back(mk(0, 1, 8'h00, 0, k == 8, 0, 0, 8 - k, 8'(k)));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h08));
    tbl.push_back(mk(1, 1, 8'h30, 0, 0, 0, 1, 1, 8'h08));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 8'h30));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h30));
    for (int j = 0; j < 4; j++) tbl.push_back(mk(1, 0, 8'(8'h10 + j), 0, 0, 0, 0, j + 1, 8'h30));
    for (int j = 0; j < 4; j++) tbl.push_back(mk(1, 1, 8'h20, 0, 0, 0, 0, 4, 8'(8'h10 + j)));
    for (int j = 0; j < 4; j++) tbl.push_back(mk(0, 1, 8'h00, 0, j == 3, 0, 0, 3 - j, 8'h20));

    // Reset held for two cycles, checked during and after.
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].din);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Asynchronous reset mid-burst clears state without a clock edge.
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    step(0, 1, 8'h00);
    check("pre_reset", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 8'hA1});
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'hA5);
    check("post_reset_wr", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'h00});
    step(0, 1, 8'h00);
    check("post_reset_rd", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'hA5});

    // Interleaved write/read pairs walk both pointers through two wraps.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'(8'h40 + i));
      check($sformatf("wrap_wr%0d", i), outs(), {1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'(i == 0 ? 8'hA5 : 8'h40 + i - 1)});
      step(0, 1, 8'h00);
      check($sformatf("wrap_rd%0d", i), outs(), {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'(8'h40 + i)});
    end

    // Randomized traffic with shifting write/read bias against a queue model.
    q.delete();
    m_dout = 8'h53;
    for (int c = 0; c < 1500; c++) begin
      int wb;
      bit w;
      bit r;
      logic [7:0] d;
      wb = (c / 150) % 3 == 0 ? 75 : ((c / 150) % 3 == 1 ? 25 : 50);
      w  = ($urandom_range(0, 99) < wb);
      r  = ($urandom_range(0, 99) < 100 - wb);
      d  = 8'($urandom);
      m_ov = w && (q.size() == DP);
      m_un = r && (q.size() == 0);
      if (r && q.size() != 0) m_dout = q.pop_front();
      if (w && !m_ov) q.push_back(d);
      step(w, r, d);
      check($sformatf("rand%0d", c), outs(),
            {q.size() == DP, q.size() == 0, m_ov, m_un, 4'(q.size()), m_dout});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
